// File: rtl/m_mem_bank.sv
// m_mem_bank: single-clock data memory bank with separate write and read
// ports, byte-enable writes, registered 1-cycle reads with valid flag,
// write-first bypass on same-address collisions and a hardware clear
// sequencer that zeroes the array after reset or on request.
module m_mem_bank #(
  parameter  int WORD  = 16,
  parameter  int DEPTH = 1024,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int BW    = WORD / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [WORD-1:0] wr_data,
  input  logic [BW-1:0]   wr_be,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [WORD-1:0] rd_data,
  output logic            rd_valid,
  output logic            ready,
  output logic            addr_err
);

  localparam logic [0:0]    ST_CLEAR = 1'b0;
  localparam logic [0:0]    ST_IDLE  = 1'b1;
  // DEPTH held one bit wider than an address so that 2^AW is representable
  localparam logic [AW:0]   DEPTH_V  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [WORD-1:0] mem [DEPTH];

  logic [0:0]      state_r;
  logic [AW-1:0]   clr_ptr_r;
  logic            ready_r;
  logic [WORD-1:0] rd_data_r;
  logic            rd_valid_r;
  logic            addr_err_r;

  logic            wr_ok_s;
  logic            rd_ok_s;
  logic            wr_acc_s;
  logic            rd_acc_s;
  logic            err_s;
  logic            collide_s;
  logic [WORD-1:0] old_word_s;
  logic [WORD-1:0] rd_word_s;

  // Request qualification and write-first merge of the word being read
  always_comb begin
    wr_ok_s    = ({1'b0, wr_addr} < DEPTH_V);
    rd_ok_s    = ({1'b0, rd_addr} < DEPTH_V);
    wr_acc_s   = ready_r & wr_en & wr_ok_s;
    rd_acc_s   = ready_r & rd_en & rd_ok_s;
    err_s      = ready_r & ((wr_en & ~wr_ok_s) | (rd_en & ~rd_ok_s));
    collide_s  = wr_acc_s & (wr_addr == rd_addr);
    old_word_s = '0;
    rd_word_s  = '0;
    if (rd_ok_s) begin
      old_word_s = mem[rd_addr];
    end else begin
      old_word_s = '0;
    end
    for (int i = 0; i < BW; i++) begin
      rd_word_s[8*i +: 8] = (collide_s && wr_be[i]) ? wr_data[8*i +: 8]
                                                     : old_word_s[8*i +: 8];
    end
  end

  // Clear sequencer: sweep every word after reset or a clr request, then serve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_CLEAR;
      clr_ptr_r <= '0;
      ready_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (clr_ptr_r == LAST_PTR) begin
            state_r   <= ST_IDLE;
            clr_ptr_r <= '0;
            ready_r   <= 1'b1;
          end else begin
            clr_ptr_r <= clr_ptr_r + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clr) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= '0;
            ready_r   <= 1'b0;
          end else begin
            ready_r   <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_CLEAR;
          clr_ptr_r <= '0;
          ready_r   <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: zeroed word by word while clearing, byte-enable writes otherwise
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem[clr_ptr_r] <= '0;
    end else if (wr_acc_s) begin
      for (int i = 0; i < BW; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Registered read data, read valid and address-error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
      addr_err_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_acc_s;
      addr_err_r <= err_s;
      if (rd_acc_s) begin
        rd_data_r <= rd_word_s;
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign ready    = ready_r;
  assign addr_err = addr_err_r;

endmodule

// File: tb/tb_m_mem_bank.sv
// Testbench for m_mem_bank (DEPTH=1000 so out-of-range addresses exist).
// A word-array reference model applies each accepted write before the
// same-cycle read (write-first) and tracks the clear sweep as a count of
// cycles remaining before the bank is ready again.
module tb_m_mem_bank;

  localparam int WORD  = 16;
  localparam int DEPTH = 1000;
  localparam int AW    = 10;
  localparam int BW    = 2;

  logic            clk;
  logic            rst_n;
  logic            clr;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [WORD-1:0] wr_data;
  logic [BW-1:0]   wr_be;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [WORD-1:0] rd_data;
  logic            rd_valid;
  logic            ready;
  logic            addr_err;

  m_mem_bank #(.WORD(WORD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .ready(ready), .addr_err(addr_err)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int              checks = 0;
  int              errors = 0;
  logic [WORD-1:0] model [DEPTH];
  int              sweep_left;
  logic            exp_ready;
  logic            exp_valid;
  logic            exp_err;
  logic [WORD-1:0] exp_data;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [WORD-1:0] obs, input logic [WORD-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    for (int a = 0; a < DEPTH; a++) model[a] = 16'h0000;
  endtask

  // Hold reset for two edges, check reset values, release away from the edge
  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = 10'd0; wr_data = 16'h0000; wr_be = 2'b00; rd_addr = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_rd_valid", rd_valid, 1'b0);
    chk16("rst_rd_data", rd_data, 16'h0000);
    chk1("rst_addr_err", addr_err, 1'b0);
    model_zero();
    sweep_left = DEPTH;
    exp_ready  = 1'b0;
    exp_valid  = 1'b0;
    exp_err    = 1'b0;
    exp_data   = 16'h0000;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive requests, advance the model, compare all outputs
  task automatic step(input logic c, input logic we, input logic [AW-1:0] wa,
                      input logic [WORD-1:0] wd, input logic [BW-1:0] wbe,
                      input logic re, input logic [AW-1:0] ra);
    clr = c; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = wbe;
    rd_en = re; rd_addr = ra;
    if (exp_ready) begin
      exp_err = (we && int'(wa) >= DEPTH) || (re && int'(ra) >= DEPTH);
      if (we && int'(wa) < DEPTH) begin
        for (int i = 0; i < BW; i++)
          if (wbe[i]) model[wa][8*i +: 8] = wd[8*i +: 8];
      end
      exp_valid = re && int'(ra) < DEPTH;
      if (exp_valid) exp_data = model[ra];
      if (c) begin
        model_zero();
        sweep_left = DEPTH;
      end
    end else begin
      exp_err   = 1'b0;
      exp_valid = 1'b0;
      if (sweep_left > 0) sweep_left--;
    end
    exp_ready = (sweep_left == 0);
    @(posedge clk);
    #1;
    chk1("ready", ready, exp_ready);
    chk1("rd_valid", rd_valid, exp_valid);
    chk16("rd_data", rd_data, exp_data);
    chk1("addr_err", addr_err, exp_err);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 10'd0, 16'h0000, 2'b00, 1'b0, 10'd0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b0, 10'd0, 16'h0000, 2'b00, 1'b1, a);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [WORD-1:0] d, input logic [BW-1:0] be);
    step(1'b0, 1'b1, a, d, be, 1'b0, 10'd0);
  endtask

  // Directed steps followed by a randomized phase and the clear/reset scenario
  initial begin
    rst_n = 1'b0;
    do_reset();

    // Reset release: ready low for exactly DEPTH cycles, array reads as zero
    for (int k = 0; k < DEPTH; k++) idle();
    chk1("t1_ready_after_sweep", ready, 1'b1);
    rd(10'h3E7);
    chk16("t1_zero_hi", rd_data, 16'h0000);
    rd(10'h000);
    chk16("t1_zero_lo", rd_data, 16'h0000);

    // Full-word write then read
    wr(10'h010, 16'hA5C3, 2'b11);
    rd(10'h010);
    chk16("t2_data", rd_data, 16'hA5C3);
    chk1("t2_valid", rd_valid, 1'b1);
    idle();
    chk1("t2_valid_drop", rd_valid, 1'b0);
    chk16("t2_hold", rd_data, 16'hA5C3);

    // wr_be=0 leaves the word alone
    wr(10'h010, 16'hFFFF, 2'b00);
    rd(10'h010);
    chk16("be0_noop", rd_data, 16'hA5C3);

    // Byte-enable partial write
    wr(10'h020, 16'h1234, 2'b11);
    wr(10'h020, 16'hABCD, 2'b01);
    rd(10'h020);
    chk16("t3_merge", rd_data, 16'h12CD);

    // Same-cycle collision returns the merged new word
    step(1'b0, 1'b1, 10'h030, 16'hBEEF, 2'b10, 1'b1, 10'h030);
    chk16("t4_bypass", rd_data, 16'hBE00);
    chk1("t4_valid", rd_valid, 1'b1);

    // Out-of-range accesses
    wr(10'd1000, 16'hFFFF, 2'b11);
    chk1("t5_err_pulse", addr_err, 1'b1);
    idle();
    chk1("t5_err_clear", addr_err, 1'b0);
    rd(10'd1000);
    chk1("t5_rd_oob_valid", rd_valid, 1'b0);
    chk1("t5_rd_oob_err", addr_err, 1'b1);
    step(1'b0, 1'b1, 10'd1023, 16'h5555, 2'b11, 1'b1, 10'd1001);
    chk1("t5_both_err", addr_err, 1'b1);
    idle();
    chk1("t5_both_err_once", addr_err, 1'b0);
    rd(10'd999);
    chk1("t5_last_ok", rd_valid, 1'b1);

    // Randomized traffic, occasional clear requests
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 299) == 0),
           1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
           16'($urandom), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? wr_addr : 10'($urandom_range(0, 1023)));
    end
    while (!exp_ready) idle();

    // Clear, then reset halfway through the sweep; reads during sweeps never valid
    step(1'b1, 1'b0, 10'd0, 16'h0000, 2'b00, 1'b0, 10'd0);
    for (int k = 0; k < 500; k++) rd(10'($urandom_range(0, 999)));
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      rd(10'($urandom_range(0, 999)));
      chk1("t6_sweep_no_valid", rd_valid, 1'b0);
    end
    chk1("t6_ready", ready, 1'b1);
    for (int a = 0; a < DEPTH; a++) begin
      rd(10'(a));
      chk16("t6_zero", rd_data, 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
